// File: rtl/cnt_mod16_axil_regs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cnt_mod16_axil_regs : AXI4-Lite register file driving a prescaled mod-16 counter
// Revision: 1.0
// ----------------------------------------------------------------------------
module cnt_mod16_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [3:0]                        cnt_o,
  output logic                              wrap_o
);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_PRESC  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic        aw_ready_q, aw_ready_d;
  logic        b_valid_q, b_valid_d;
  logic        ar_ready_q, ar_ready_d;
  logic        r_valid_q, r_valid_d;
  logic [31:0] r_data_q, r_data_d;
  logic        en_q, en_d;
  logic        dir_q, dir_d;
  logic [3:0]  load_q, load_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wrap_q, wrap_d;
  logic        wrap_flag_q, wrap_flag_d;

  logic        wr_fire, rd_fire, wr_ctrl, clr, ld, presc_wr, w1c, tick, wrap_evt;
  logic [1:0]  wr_reg, rd_reg;
  logic [31:0] rd_mux;
  logic        unused_inputs;

  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                           S_AXI_WDATA[31:16], S_AXI_WDATA[7:4], S_AXI_WSTRB[3:2]};

  always_comb begin
    wr_reg      = S_AXI_AWADDR[3:2];
    rd_reg      = S_AXI_ARADDR[3:2];
    // Handshakes complete on the edge where the one-cycle READY pulse is seen high.
    wr_fire     = aw_ready_q & S_AXI_AWVALID & S_AXI_WVALID;
    rd_fire     = ar_ready_q & S_AXI_ARVALID;

    aw_ready_d  = S_AXI_AWVALID & S_AXI_WVALID & ~b_valid_q & ~aw_ready_q;
    b_valid_d   = wr_fire | (b_valid_q & ~S_AXI_BREADY);
    ar_ready_d  = S_AXI_ARVALID & ~r_valid_q & ~ar_ready_q;
    r_valid_d   = rd_fire | (r_valid_q & ~S_AXI_RREADY);

    wr_ctrl     = wr_fire & (wr_reg == REG_CTRL) & S_AXI_WSTRB[0];
    clr         = wr_ctrl & S_AXI_WDATA[2];
    ld          = wr_ctrl & S_AXI_WDATA[3];
    presc_wr    = wr_fire & (wr_reg == REG_PRESC);
    w1c         = wr_fire & (wr_reg == REG_STATUS) & S_AXI_WSTRB[1] & S_AXI_WDATA[8];

    en_d        = wr_ctrl ? S_AXI_WDATA[0] : en_q;
    dir_d       = wr_ctrl ? S_AXI_WDATA[1] : dir_q;
    load_d      = (wr_fire & (wr_reg == REG_LOAD) & S_AXI_WSTRB[0]) ? S_AXI_WDATA[3:0] : load_q;
    presc_d     = presc_q;
    if (presc_wr & S_AXI_WSTRB[0]) presc_d[7:0]  = S_AXI_WDATA[7:0];
    if (presc_wr & S_AXI_WSTRB[1]) presc_d[15:8] = S_AXI_WDATA[15:8];

    tick        = en_q & (presc_cnt_q == presc_q);
    presc_cnt_d = (~en_q | presc_wr | tick) ? 16'd0 : presc_cnt_q + 16'd1;

    wrap_evt    = tick & ~clr & ~ld & (dir_q ? (cnt_q == 4'd0) : (cnt_q == 4'd15));
    if (clr)       cnt_d = 4'd0;
    else if (ld)   cnt_d = load_q;
    else if (tick) cnt_d = dir_q ? cnt_q - 4'd1 : cnt_q + 4'd1;
    else           cnt_d = cnt_q;

    wrap_d      = wrap_evt;
    // A wrap on the same edge as a W1C clear keeps the flag set.
    wrap_flag_d = wrap_evt | (wrap_flag_q & ~w1c);

    case (rd_reg)
      REG_CTRL:   rd_mux = {30'd0, dir_q, en_q};
      REG_LOAD:   rd_mux = {28'd0, load_q};
      REG_PRESC:  rd_mux = {16'd0, presc_q};
      REG_STATUS: rd_mux = {23'd0, wrap_flag_q, 4'd0, cnt_q};
      default:    rd_mux = 32'd0;
    endcase
    r_data_d    = rd_fire ? rd_mux : r_data_q;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_ready_q  <= 1'b0;
      b_valid_q   <= 1'b0;
      ar_ready_q  <= 1'b0;
      r_valid_q   <= 1'b0;
      r_data_q    <= 32'd0;
      en_q        <= 1'b0;
      dir_q       <= 1'b0;
      load_q      <= 4'd0;
      presc_q     <= 16'd0;
      presc_cnt_q <= 16'd0;
      cnt_q       <= 4'd0;
      wrap_q      <= 1'b0;
      wrap_flag_q <= 1'b0;
    end else begin
      aw_ready_q  <= aw_ready_d;
      b_valid_q   <= b_valid_d;
      ar_ready_q  <= ar_ready_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      en_q        <= en_d;
      dir_q       <= dir_d;
      load_q      <= load_d;
      presc_q     <= presc_d;
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      wrap_flag_q <= wrap_flag_d;
    end
  end

  assign S_AXI_AWREADY = aw_ready_q;
  assign S_AXI_WREADY  = aw_ready_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = b_valid_q;
  assign S_AXI_ARREADY = ar_ready_q;
  assign S_AXI_RDATA   = r_data_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_valid_q;
  assign cnt_o         = cnt_q;
  assign wrap_o        = wrap_q;

endmodule
`default_nettype wire

// File: doc/cnt_mod16_axil_regs.md
Name: cnt_mod16_axil_regs

Overview:
AXI4-Lite slave register file plus mod-16 counter core: the block the AXI VIP master drives directly in the CNT_MOD16 IP. It decodes four 32-bit registers (control, load value, prescaler, status) and runs a prescaled up/down 4-bit counter. Count and wrap pulse are also exported for fabric use.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 4, AXI byte address width; bits [3:2] select the register.

Ports:
ACLK  in  1  clock; all logic is on the rising edge.
ARESET  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  4  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID  in  1  write address valid.
S_AXI_AWREADY  out  1  write address ready.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte strobes.
S_AXI_WVALID  in  1  write data valid.
S_AXI_WREADY  out  1  write data ready.
S_AXI_BRESP  out  2  always 2'b00 (OKAY).
S_AXI_BVALID  out  1  write response valid.
S_AXI_BREADY  in  1  write response ready.
S_AXI_ARADDR  in  4  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID  in  1  read address valid.
S_AXI_ARREADY  out  1  read address ready.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  always 2'b00.
S_AXI_RVALID  out  1  read data valid.
S_AXI_RREADY  in  1  read data ready.
cnt_o  out  4  current count.
wrap_o  out  1  one-cycle pulse on wrap.

Behaviour:
- Reset (asynchronous, ARESET=1): all registers, count, prescale counter, sticky flag, and every output are 0. All READY and VALID outputs are low.
- Write channel: AWREADY and WREADY pulse high together for exactly one cycle when AWVALID & WVALID & ~BVALID & ~AWREADY. The register updates on that same edge.
- BVALID rises on the next cycle and holds until BREADY is sampled high. No new write is accepted while BVALID=1.
- Read channel: ARREADY pulses for one cycle when ARVALID & ~RVALID & ~ARREADY. RDATA is registered on that edge, so RVALID follows one cycle after the ARREADY pulse.
- RDATA and RVALID hold until RREADY. Read and write channels are independent and may complete in the same cycle.
- WSTRB applies per byte. Unimplemented bits read 0.
- 0x0 CTRL: bit0 EN, bit1 DIR (0 = up, 1 = down); both RW. bit2 CLR and bit3 LD are write-1 self-clearing pulses that always read 0.
- 0x4 LOAD: [3:0] RW.
- 0x8 PRESC: [15:0] RW. Any write to it resets the prescale counter to 0.
- 0xC STATUS: [3:0] count (RO); [8] WRAP sticky flag. Writing 1 to bit 8 clears the flag (W1C).
- Tick: applies while EN=1. The prescale counter increments each cycle; when it equals PRESC, it returns to 0 and a tick fires. With PRESC=0, a tick fires every cycle.
- With EN=0, the prescale counter holds at 0.
- Count precedence per cycle: CLR (to 0) > LD (to LOAD) > tick (±1 mod 16). CLR and LD take effect on the write-accept edge.
- Wrap: a tick taking 15→0 (up) or 0→15 (down) pulses wrap_o for 1 cycle and sets WRAP. CLR and LD never set wrap.
- If WRAP is set and W1C-cleared in the same cycle, set wins.
- A read of STATUS returns the count as registered at the ARREADY edge.
- ARESET asserted mid-transaction aborts it. No response is issued after reset release.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC → all 0x00000000, cnt_o=0, wrap_o=0.
- Write LOAD=0x5, CTRL=0x8, read STATUS → 0x00000005, and CTRL reads 0x0.
- PRESC=3, CTRL=0x1 → cnt_o increments every 4 ACLK; from 15 → 0 with a 1-cycle wrap_o pulse; STATUS then reads 0x100.
- Write 0x100 to 0xC → STATUS[8]=0. Coincident wrap tick and W1C write → STATUS[8] stays 1.
- CTRL=0x3, PRESC=0, count=0 → next cycle cnt_o=15 with wrap_o pulse. Write CTRL=0x7 at the same time as a tick → cnt_o=0, no wrap.
- Hold BREADY/RREADY low for 10 cycles → BVALID/RVALID stay asserted and no second AWREADY pulse occurs. Write WSTRB=0x0 to PRESC → value unchanged.
